// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage initiator for a word-addressed data memory. Takes one
//   load/store at a time over a valid/ready handshake, converts the byte
//   address into a word index, extracts and extends sub-word loads, and
//   performs read-modify-write for byte/half stores (the memory only writes
//   whole words). Every request gets exactly one response; misaligned,
//   illegal-size or out-of-range requests respond with a fault and never
//   touch memory. Byte order is big-endian (offset 0 = bits [31:24]).
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake; ready is high only when idle
//   req_write          1 = store, 0 = load
//   req_size           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned       loads: 1 = zero-extend, 0 = sign-extend
//   req_addr           byte address
//   req_wdata          store data, right-justified
//   resp_valid         one-cycle response pulse
//   resp_data          load result (0 for stores and faults)
//   resp_fault         request faulted
//   mem_address        word index presented to memory
//   mem_write_enable   whole-word write strobe
//   mem_data_in        memory write data
//   mem_data_out       memory read data (registered read)
module load_store_unit #(
   parameter int MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_t;

   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        unsigned_q, unsigned_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;

   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        resp_fault_q, resp_fault_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_data_in_q, mem_data_in_d;

   logic        accept;
   logic        req_fault;
   logic [7:0]  lane_byte [4];
   logic [31:0] st_merge;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;

   assign accept = req_valid && req_ready_q;

   always_comb begin
      req_fault = 1'b0;
      if (req_size == 2'b11)                          req_fault = 1'b1;
      if (req_size == 2'b01 && req_addr[0])           req_fault = 1'b1;
      if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_fault = 1'b1;
      if ({2'b00, req_addr[31:2]} >= MEM_WORDS_W)      req_fault = 1'b1;
   end

   // Per-lane view of the read word and the merged store word. A lane is
   // overwritten when it is the addressed byte, or one of the two bytes of
   // the addressed half (high byte of the half lands in the even lane).
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic lane_hit;
         logic [7:0] lane_wbyte;
         assign lane_byte[gi] = mem_data_out[31-8*gi -: 8];
         assign lane_hit = (size_q == 2'b00 && off_q == LANE) ||
                           (size_q == 2'b01 && off_q[1] == LANE[1]);
         assign lane_wbyte = (size_q == 2'b01 && !LANE[0]) ? wdata_q[15:8] : wdata_q[7:0];
         assign st_merge[31-8*gi -: 8] = lane_hit ? lane_wbyte : lane_byte[gi];
      end
   endgenerate

   assign ld_byte = lane_byte[off_q];
   assign ld_half = off_q[1] ? mem_data_out[15:0] : mem_data_out[31:16];

   always_comb begin
      case (size_q)
         2'b00:   ld_value = unsigned_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_value = unsigned_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_value = mem_data_out;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      size_d        = size_q;
      unsigned_d    = unsigned_q;
      off_d         = off_q;
      wdata_d       = wdata_q;
      resp_data_d   = resp_data_q;
      resp_fault_d  = resp_fault_q;
      mem_address_d = mem_address_q;
      mem_data_in_d = mem_data_in_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               write_d      = req_write;
               size_d       = req_size;
               unsigned_d   = req_unsigned;
               off_d        = req_addr[1:0];
               wdata_d      = req_wdata;
               resp_data_d  = 32'd0;
               resp_fault_d = 1'b0;
               if (req_fault) begin
                  resp_fault_d = 1'b1;
                  state_d      = DONE;
               end else if (req_write && req_size == 2'b10) begin
                  mem_address_d = {2'b00, req_addr[31:2]};
                  mem_data_in_d = req_wdata;
                  state_d       = WR_ISSUE;
               end else begin
                  mem_address_d = {2'b00, req_addr[31:2]};
                  state_d       = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: state_d = RD_WAIT;
         RD_WAIT: begin
            if (write_q) begin
               mem_data_in_d = st_merge;
               state_d       = WR_ISSUE;
            end else begin
               resp_data_d = ld_value;
               state_d     = DONE;
            end
         end
         WR_ISSUE: state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase

      // Handshake and strobe outputs are registered copies of the next state.
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == DONE);
      mem_we_d     = (state_d == WR_ISSUE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         write_q       <= 1'b0;
         size_q        <= 2'b00;
         unsigned_q    <= 1'b0;
         off_q         <= 2'b00;
         wdata_q       <= 32'd0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_data_q   <= 32'd0;
         resp_fault_q  <= 1'b0;
         mem_address_q <= 32'd0;
         mem_we_q      <= 1'b0;
         mem_data_in_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         size_q        <= size_d;
         unsigned_q    <= unsigned_d;
         off_q         <= off_d;
         wdata_q       <= wdata_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_data_q   <= resp_data_d;
         resp_fault_q  <= resp_fault_d;
         mem_address_q <= mem_address_d;
         mem_we_q      <= mem_we_d;
         mem_data_in_q <= mem_data_in_d;
      end
   end

   assign req_ready        = req_ready_q;
   assign resp_valid       = resp_valid_q;
   assign resp_data        = resp_data_q;
   assign resp_fault       = resp_fault_q;
   assign mem_address      = mem_address_q;
   assign mem_write_enable = mem_we_q;
   assign mem_data_in      = mem_data_in_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage initiator that drives the word-addressed data memory on behalf of the pipeline. Accepts one load/store request at a time over a valid/ready handshake. Converts byte addresses to word indices, extracts and extends sub-word loads, and performs read-modify-write for byte/half stores, because the memory writes only whole words. Returns one response per request, with a fault flag for misaligned or out-of-range accesses.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the attached data memory; word indices >= MEM_WORDS fault

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted on posedge when req_valid && req_ready
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (faults)
req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified for byte/half
resp_valid  output  1  one-cycle pulse, response fields valid
resp_data  output  32  load result; 0 for stores and faults
resp_fault  output  1  misaligned, illegal size or out-of-range access
mem_address  output  32  word index to data memory = {2'b00, addr[31:2]}
mem_write_enable  output  1  whole-word write strobe
mem_data_in  output  32  write data to memory
mem_data_out  input  32  memory read data, registered; valid the cycle after a cycle with mem_write_enable=0

Behaviour:
- Clock and reset: clk, with rst synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_fault=0, mem_write_enable=0, mem_address=0, mem_data_in=0.
- Byte order is big-endian. Byte offset 0 is bits [31:24]. Half offset 0 is bits [31:16].
- Accept-time checks produce a fault when any of these hold:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS.
- A faulting request makes no memory access.
- req_ready=1 only in IDLE. Request fields are latched on acceptance.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE.
- Transitions out of IDLE on accept:
  - fault -> DONE (resp_fault=1);
  - load or byte/half store -> RD_ISSUE;
  - word store -> WR_ISSUE (mem_data_in=req_wdata).
- RD_ISSUE: mem_address=word index, mem_write_enable=0 -> RD_WAIT.
- RD_WAIT: mem_data_out is valid here. Next state:
  - Load: extract the byte/half/word, sign- or zero-extend it, register it into resp_data -> DONE.
  - Sub-word store: merge req_wdata[7:0] or [15:0] into the addressed lane of mem_data_out, register the result into mem_data_in -> WR_ISSUE.
- WR_ISSUE: mem_write_enable=1 for exactly this one cycle -> DONE.
- DONE: resp_valid=1 for one cycle -> IDLE. resp_fault and resp_data are cleared on the next accept.
- Latency from the accept edge to the resp_valid cycle:
  - fault: 1 cycle;
  - SW: 2 cycles;
  - load: 3 cycles;
  - SB/SH: 4 cycles.
- Throughput: one request per (latency+1) cycles. A new request is accepted only in IDLE.
- mem_address holds its last value outside RD_ISSUE/WR_ISSUE. mem_write_enable is 0 in every state except WR_ISSUE.
- Reset mid-operation: the next state is IDLE with reset output values. The pending request is dropped with no response. Any write not yet issued never occurs.
- rst takes priority over a simultaneous req_valid.

Test Plan:
1. Word store: after rst, SW addr 0x8 data 0xDEADBEEF -> exactly one cycle with mem_write_enable=1, mem_address=2, mem_data_in=0xDEADBEEF; resp_valid 2 cycles after accept, resp_fault=0.
2. Loads from word 2 = 0xDEADBEEF, each resp_valid 3 cycles after accept:
   - LW 0x8 -> 0xDEADBEEF
   - LB 0x9 -> 0xFFFFFFAD
   - LBU 0x9 -> 0x000000AD
   - LH 0xA -> 0xFFFFBEEF
   - LHU 0x8 -> 0x0000DEAD
3. Sub-word stores: SB 0xB data 0x11 -> one read cycle, then a write of 0xDEADBE11; resp 4 cycles after accept. Then SH 0x8 data 0x1234 -> memory word 2 = 0x1234BE11, confirmed by LW.
4. Faults: LW 0x6, LH 0x3, req_size=11, LW 0x80 (index 32) -> resp_fault=1, resp_data=0 one cycle after accept; mem_write_enable never asserted; memory unchanged.
5. Reset mid-operation: rst asserted while in RD_WAIT of an SB -> next cycle req_ready=1, resp_valid=0, no write pulse; the target word is unchanged.
6. Held request: req_valid held high with a second request queued behind an SW -> req_ready=0 for 2 cycles; the second request is accepted in the IDLE cycle after DONE; two resp_valid pulses total.
